pipe_wbu: RTL and testbench
===========================

PIPE_WBU -- requirements
Module: pipe_wbu

Interface
REQ-001 Parameter CNT_W, default 64: width of the retired-instruction counter.
REQ-002 Parameter HALT_ON_EBREAK, default 1: when 1, a retired EBREAK halts the stage.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 exToWb_i  input  exToWb_t  EX result bundle: uop_info, alu_res, lsu_res.
REQ-006 ex_valid_i  input  1  EX holds a valid bundle.
REQ-007 wb_ready_o  output  1  WB can accept a bundle this cycle.
REQ-008 wb_fwd_valid_o  output  1  WB holds a register-writing instruction.
REQ-009 wb_fwd_rd_o  output  5  destination register being forwarded.
REQ-010 wb_fwd_data_o  output  ele_t  value being forwarded.
REQ-011 rf_we_o  output  1  register-file write enable.
REQ-012 rf_waddr_o  output  5  register-file write index.
REQ-013 rf_wdata_o  output  ele_t  register-file write data.
REQ-014 commit_valid_o  output  1  one instruction retires this cycle.
REQ-015 commit_pc_o  output  pc_t  PC of the retiring instruction.
REQ-016 retire_cnt_o  output  CNT_W  count of retired instructions.
REQ-017 halt_o  output  1  stage halted after EBREAK.

Function
REQ-018 Single-entry stage register: fields wb_valid_q and exToWb_q.
- Bundle is accepted on a clock edge when ex_valid_i && wb_ready_o.
REQ-019 In state RUN, wb_ready_o SHALL be 1.
- Every held bundle retires in its first WB cycle; no back-pressure is generated.
REQ-020 In state HALT, wb_ready_o SHALL be 0.
- wb_valid_q clears on entry to HALT and remains 0.
REQ-021 Latency: a bundle accepted at edge N is in WB during cycle N+1.
- rf write lands at edge N+1.
- commit_valid_o is high during cycle N+1.
REQ-022 Result select:
- res = exToWb_q.lsu_res when uop_info.fu_op == LOAD.
- res = exToWb_q.alu_res otherwise.
REQ-023 wr = wb_valid_q && uop_info.rd_wen && uop_info.rd != 0.
- Writes to x0 are always suppressed.
REQ-024 Write port: rf_we_o = wr, rf_waddr_o = uop_info.rd, rf_wdata_o = res.
- All three are combinational from the stage register.
REQ-025 Forward port: wb_fwd_valid_o = wr, wb_fwd_rd_o = uop_info.rd, wb_fwd_data_o = res.
- Same cycle as the rf write, so EX sees the value before the register file updates.
REQ-026 commit_valid_o = wb_valid_q.
- commit_pc_o = uop_info.pc, valid only while commit_valid_o is high.
REQ-027 retire_cnt_o increments by 1 on every cycle with commit_valid_o.
- It wraps modulo 2^CNT_W with no saturation.
REQ-028 State machine, two states:
- RUN -> HALT at the edge ending a cycle in which wb_valid_q, fu_op == EBREAK and HALT_ON_EBREAK == 1.
- HALT is terminal until reset.
REQ-029 A retiring EBREAK still commits and increments retire_cnt_o.
- It writes no register unless rd_wen is set.
REQ-030 halt_o = (state == HALT).
REQ-031 With HALT_ON_EBREAK == 0, EBREAK retires like any other uop and the state stays RUN.
REQ-032 Simultaneous retire and accept is the normal steady state: one instruction per cycle.

Reset
REQ-033 Reset values:
- state = RUN, wb_valid_q = 0, retire_cnt_o = 0.
- Consequently rf_we_o, wb_fwd_valid_o, commit_valid_o and halt_o are 0, and wb_ready_o is 1.
REQ-034 exToWb_q is not reset; every output derived from it is qualified by wb_valid_q.
REQ-035 Reset asserted mid-operation drops the held instruction without a register write.
- The counter clears; the first accept after deassertion is handled normally.

Structure
REQ-036 Shared typedefs and constants live in liang_pkg:
- exToWb_t, uop_info_t (with fields rd, rd_wen, pc, fu_op), ele_t, pc_t.
- fu_op enumerators LOAD and EBREAK.
REQ-037 WB-local two-state enum wb_state_e is declared inside pipe_wbu.
REQ-038 No sub-module is required.
- The result mux, counter and state machine are coded inline.

Verification
REQ-039 Bundle rd=5, rd_wen=1, fu_op=ADD, alu_res=0x1234, accepted at edge N:
- during cycle N+1: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234, wb_fwd_valid_o=1, commit_valid_o=1.
- retire_cnt_o = 1 after edge N+1.
REQ-040 LOAD with lsu_res=0xDEAD, alu_res=0x1000, rd=7:
- rf_wdata_o = wb_fwd_data_o = 0xDEAD.
REQ-041 rd=0, rd_wen=1:
- rf_we_o = 0 and wb_fwd_valid_o = 0.
- commit_valid_o = 1 and the counter increments.
REQ-042 Ten back-to-back valid bundles, then EBREAK (HALT_ON_EBREAK=1), then more valids:
- retire_cnt_o = 11.
- halt_o = 1 from the cycle after EBREAK retires.
- wb_ready_o = 0 and no further commits.
REQ-043 Counter preloaded near wrap, CNT_W=4, 17 retires:
- retire_cnt_o = 1.
REQ-044 rst_i pulsed asynchronously while a valid write is held:
- rf_we_o drops immediately and no write occurs.
- retire_cnt_o = 0, halt_o = 0.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared pipeline typedefs: data/PC widths, functional-unit opcodes and
// the EX->WB result bundle consumed by the writeback stage.
package liang_pkg;

  localparam int XLEN = 64;
  localparam int PC_W = 64;
  localparam int REG_IDX_W = 5;

  typedef logic [XLEN-1:0]      ele_t;
  typedef logic [PC_W-1:0]      pc_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Functional-unit operation carried with each micro-op.
  typedef enum logic [2:0] {
    ADD    = 3'd0,
    SUB    = 3'd1,
    SLT    = 3'd2,
    SHIFT  = 3'd3,
    LOAD   = 3'd4,
    STORE  = 3'd5,
    BRANCH = 3'd6,
    EBREAK = 3'd7
  } fu_op_e;

  typedef struct packed {
    pc_t      pc;
    reg_idx_t rd;
    logic     rd_wen;
    fu_op_e   fu_op;
  } uop_info_t;

  typedef struct packed {
    uop_info_t uop_info;
    ele_t      alu_res;
    ele_t      lsu_res;
  } exToWb_t;

endpackage

// File: rtl/pipe_wbu.sv
// Writeback stage: single-entry stage register fed by EX. Each held bundle
// retires in its first WB cycle, driving the register-file write port, the
// EX forwarding port and the commit/retire counter. A retiring EBREAK can
// halt the stage until reset.
module pipe_wbu
  import liang_pkg::*;
#(
  parameter int CNT_W          = 64,
  parameter int HALT_ON_EBREAK = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  exToWb_t          exToWb_i,
  input  logic             ex_valid_i,
  output logic             wb_ready_o,
  output logic             wb_fwd_valid_o,
  output logic [4:0]       wb_fwd_rd_o,
  output ele_t             wb_fwd_data_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output ele_t             rf_wdata_o,
  output logic             commit_valid_o,
  output pc_t              commit_pc_o,
  output logic [CNT_W-1:0] retire_cnt_o
  ,
  output logic             halt_o
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_e;

  wb_state_e        state_q;
  logic             wb_valid_q;
  exToWb_t          exToWb_q;
  logic [CNT_W-1:0] retire_cnt_q;

  logic             accept;
  logic             halt_now;
  logic             wr;
  ele_t             res;

  // No back-pressure while running: the held bundle always retires this cycle.
  assign wb_ready_o = (state_q == RUN);
  assign accept     = ex_valid_i && wb_ready_o;

  // An EBREAK sitting in WB ends the run at the close of its retire cycle.
  assign halt_now = wb_valid_q
                 && (exToWb_q.uop_info.fu_op == EBREAK)
                 && (HALT_ON_EBREAK != 0);

  // Control state: run/halt FSM, stage-valid flag and retire counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      wb_valid_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      if (wb_valid_q) begin
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
      case (state_q)
        RUN: begin
          if (halt_now) begin
            state_q    <= HALT;
            wb_valid_q <= 1'b0;
          end else begin
            wb_valid_q <= accept;
          end
        end
        HALT: begin
          wb_valid_q <= 1'b0;
        end
        default: begin
          state_q    <= RUN;
          wb_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload register; left unreset because every consumer is gated by wb_valid_q.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      exToWb_q <= exToWb_i;
    end
  end

  // Result select: loads take the memory data, everything else the ALU value.
  always_comb begin
    res = exToWb_q.alu_res;
    if (exToWb_q.uop_info.fu_op == LOAD) begin
      res = exToWb_q.lsu_res;
    end
  end

  // x0 is hardwired to zero, so its writes are never performed or forwarded.
  assign wr = wb_valid_q && exToWb_q.uop_info.rd_wen && (exToWb_q.uop_info.rd != '0);

  assign rf_we_o        = wr;
  assign rf_waddr_o     = exToWb_q.uop_info.rd;
  assign rf_wdata_o     = res;

  assign wb_fwd_valid_o = wr;
  assign wb_fwd_rd_o    = exToWb_q.uop_info.rd;
  assign wb_fwd_data_o  = res;

  assign commit_valid_o = wb_valid_q;
  assign commit_pc_o    = exToWb_q.uop_info.pc;
  assign retire_cnt_o   = retire_cnt_q;
  assign halt_o         = (state_q == HALT);

endmodule

// File: tb/tb_pipe_wbu.sv
// Directed bench for pipe_wbu with a commit scoreboard. Three instances share
// stimulus: the default configuration, a 4-bit counter copy and a copy that
// does not halt on EBREAK.
module tb_pipe_wbu;
  import liang_pkg::*;

  logic    clk_i = 1'b0;
  logic    rst_i = 1'b1;
  exToWb_t ex_bundle;
  logic    ex_valid;

  // main DUT outputs
  logic        wb_ready, fwd_valid, rf_we, commit_valid, halt;
  logic [4:0]  fwd_rd, rf_waddr;
  ele_t        fwd_data, rf_wdata;
  pc_t         commit_pc;
  logic [63:0] retire_cnt;

  // 4-bit counter DUT outputs
  logic        w4_ready, w4_fwd_valid, w4_we, w4_commit, w4_halt;
  logic [4:0]  w4_fwd_rd, w4_waddr;
  ele_t        w4_fwd_data, w4_wdata;
  pc_t         w4_pc;
  logic [3:0]  w4_cnt;

  // no-halt DUT outputs
  logic        nh_ready, nh_fwd_valid, nh_we, nh_commit, nh_halt;
  logic [4:0]  nh_fwd_rd, nh_waddr;
  ele_t        nh_fwd_data, nh_wdata;
  pc_t         nh_pc;
  logic [63:0] nh_cnt;

  pipe_wbu dut (
    .clk_i(clk_i), .rst_i(rst_i), .exToWb_i(ex_bundle), .ex_valid_i(ex_valid),
    .wb_ready_o(wb_ready), .wb_fwd_valid_o(fwd_valid), .wb_fwd_rd_o(fwd_rd),
    .wb_fwd_data_o(fwd_data), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr),
    .rf_wdata_o(rf_wdata), .commit_valid_o(commit_valid), .commit_pc_o(commit_pc),
    .retire_cnt_o(retire_cnt), .halt_o(halt)
  );

  pipe_wbu #(.CNT_W(4)) dut_w4 (
    .clk_i(clk_i), .rst_i(rst_i), .exToWb_i(ex_bundle), .ex_valid_i(ex_valid),
    .wb_ready_o(w4_ready), .wb_fwd_valid_o(w4_fwd_valid), .wb_fwd_rd_o(w4_fwd_rd),
    .wb_fwd_data_o(w4_fwd_data), .rf_we_o(w4_we), .rf_waddr_o(w4_waddr),
    .rf_wdata_o(w4_wdata), .commit_valid_o(w4_commit), .commit_pc_o(w4_pc),
    .retire_cnt_o(w4_cnt), .halt_o(w4_halt)
  );

  pipe_wbu #(.HALT_ON_EBREAK(0)) dut_nh (
    .clk_i(clk_i), .rst_i(rst_i), .exToWb_i(ex_bundle), .ex_valid_i(ex_valid),
    .wb_ready_o(nh_ready), .wb_fwd_valid_o(nh_fwd_valid), .wb_fwd_rd_o(nh_fwd_rd),
    .wb_fwd_data_o(nh_fwd_data), .rf_we_o(nh_we), .rf_waddr_o(nh_waddr),
    .rf_wdata_o(nh_wdata), .commit_valid_o(nh_commit), .commit_pc_o(nh_pc),
    .retire_cnt_o(nh_cnt), .halt_o(nh_halt)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        ebreak;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_held;
  logic        m_held_valid = 1'b0;
  logic        m_halt = 1'b0;
  logic        nh_held = 1'b0;
  logic [63:0] m_cnt = '0;
  logic [63:0] m_cnt_nh = '0;
  logic [63:0] pc_ctr = 64'h8000_0000;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present one bundle to all DUTs; push the expected commit if the main DUT accepts it.
  task automatic drive(input logic v, input fu_op_e op, input logic [4:0] rd,
                       input logic wen, input logic [63:0] alu, input logic [63:0] lsu);
    exp_t e;
    ex_valid                  = v;
    ex_bundle.uop_info.pc     = pc_ctr;
    ex_bundle.uop_info.rd     = rd;
    ex_bundle.uop_info.rd_wen = wen;
    ex_bundle.uop_info.fu_op  = op;
    ex_bundle.alu_res         = alu;
    ex_bundle.lsu_res         = lsu;
    if (v && !m_halt) begin
      e.pc     = pc_ctr;
      e.we     = wen && (rd != 5'd0);
      e.rd     = rd;
      e.data   = (op == LOAD) ? lsu : alu;
      e.ebreak = (op == EBREAK);
      sb.push_back(e);
    end
    pc_ctr = pc_ctr + 64'd4;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, fu_op_e'($urandom_range(0, 6)), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Advance one clock, update the models, then compare every output against them.
  task automatic tick();
    logic acc, nh_acc, enter;
    exp_t e;
    acc    = ex_valid && !m_halt;
    nh_acc = ex_valid;
    enter  = 1'b0;
    @(posedge clk_i);
    if (m_held_valid) begin
      m_cnt = m_cnt + 64'd1;
      if (m_held.ebreak) enter = 1'b1;
    end
    if (nh_held) m_cnt_nh = m_cnt_nh + 64'd1;
    nh_held = nh_acc;
    if (acc) begin
      if (sb.size() > 0) e = sb.pop_front();
      else chk("sb_underflow", 64'd1, 64'd0);
    end
    if (enter) begin
      m_halt       = 1'b1;
      m_held_valid = 1'b0;
    end else begin
      m_held_valid = acc;
      if (acc) m_held = e;
    end
    #1;
    chk("commit_valid", commit_valid, m_held_valid);
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("halt", halt, m_halt);
    chk("wb_ready", wb_ready, !m_halt);
    chk("w4_cnt", w4_cnt, m_cnt[3:0]);
    chk("nh_cnt", nh_cnt, m_cnt_nh);
    chk("nh_halt", nh_halt, 1'b0);
    if (m_held_valid) begin
      chk("commit_pc", commit_pc, m_held.pc);
      chk("rf_we", rf_we, m_held.we);
      chk("fwd_valid", fwd_valid, m_held.we);
      chk("rf_waddr", rf_waddr, m_held.rd);
      chk("fwd_rd", fwd_rd, m_held.rd);
      chk("rf_wdata", rf_wdata, m_held.data);
      chk("fwd_data", fwd_data, m_held.data);
    end else begin
      chk("rf_we_idle", rf_we, 1'b0);
      chk("fwd_valid_idle", fwd_valid, 1'b0);
    end
    $display("t=%0t cyc: valid_in=%0b commit=%0b pc=%h we=%0b rd=%0d data=%h cnt=%0d halt=%0b",
             $time, ex_valid, commit_valid, commit_pc, rf_we, rf_waddr, rf_wdata, retire_cnt, halt);
  endtask

  task automatic model_reset();
    sb.delete();
    m_held_valid = 1'b0;
    m_halt       = 1'b0;
    nh_held      = 1'b0;
    m_cnt        = '0;
    m_cnt_nh     = '0;
  endtask

  initial begin
    ex_valid  = 1'b0;
    ex_bundle = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    chk("rst_commit", commit_valid, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_ready", wb_ready, 1'b1);
    chk("rst_cnt", retire_cnt, 64'd0);
    #3 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // ADD rd=5 -> 0x1234
    drive(1'b1, ADD, 5'd5, 1'b1, 64'h1234, 64'h0);
    tick();
    chk("add_we", rf_we, 1'b1);
    chk("add_waddr", rf_waddr, 64'd5);
    chk("add_wdata", rf_wdata, 64'h1234);
    chk("add_fwd_valid", fwd_valid, 1'b1);
    chk("add_commit", commit_valid, 1'b1);

    // LOAD rd=7 selects lsu_res
    drive(1'b1, LOAD, 5'd7, 1'b1, 64'h1000, 64'hDEAD);
    tick();
    chk("add_cnt", retire_cnt, 64'd1);
    chk("load_wdata", rf_wdata, 64'hDEAD);
    chk("load_fwd_data", fwd_data, 64'hDEAD);

    // rd=0 write suppressed but still commits
    drive(1'b1, ADD, 5'd0, 1'b1, 64'hFFFF, 64'h0);
    tick();
    chk("x0_we", rf_we, 1'b0);
    chk("x0_fwd_valid", fwd_valid, 1'b0);
    chk("x0_commit", commit_valid, 1'b1);
    chk("x0_cnt_before", retire_cnt, 64'd2);

    // rd_wen=0
    drive(1'b1, SUB, 5'd3, 1'b0, 64'h55, 64'h0);
    tick();
    chk("nowen_we", rf_we, 1'b0);
    chk("x0_cnt_after", retire_cnt, 64'd3);

    // 13 more retires (17 total) including a bubble, then drain
    for (int i = 0; i < 13; i++) begin
      drive_rand(1'b1);
      tick();
      if (i == 6) begin
        drive_rand(1'b0);
        tick();
      end
    end
    drive_rand(1'b0);
    tick();
    chk("wrap_cnt64", retire_cnt, 64'd17);
    chk("wrap_cnt4", w4_cnt, 64'd1);

    // Asynchronous reset while a write is held
    drive(1'b1, ADD, 5'd9, 1'b1, 64'hABCD, 64'h0);
    tick();
    chk("pre_rst_we", rf_we, 1'b1);
    drive(1'b0, ADD, 5'd0, 1'b0, 64'h0, 64'h0);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    chk("arst_we", rf_we, 1'b0);
    chk("arst_fwd_valid", fwd_valid, 1'b0);
    chk("arst_commit", commit_valid, 1'b0);
    chk("arst_cnt", retire_cnt, 64'd0);
    chk("arst_halt", halt, 1'b0);
    #1 rst_i = 1'b0;

    // Ten valids, EBREAK, three more valids
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      tick();
    end
    drive(1'b1, EBREAK, 5'd1, 1'b0, 64'h77, 64'h0);
    tick();
    chk("ebreak_commit", commit_valid, 1'b1);
    chk("ebreak_we", rf_we, 1'b0);
    chk("ebreak_not_yet_halted", halt, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
    end
    drive_rand(1'b0);
    tick();
    tick();
    chk("halt_cnt", retire_cnt, 64'd11);
    chk("halt_flag", halt, 1'b1);
    chk("halt_ready", wb_ready, 1'b0);
    chk("halt_commit", commit_valid, 1'b0);
    chk("nh_cnt_total", nh_cnt, 64'd14);
    chk("nh_stays_run", nh_ready, 1'b1);

    // Reset releases HALT
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst2_halt", halt, 1'b0);
    chk("rst2_ready", wb_ready, 1'b1);
    #1 rst_i = 1'b0;
    drive(1'b1, ADD, 5'd12, 1'b1, 64'h42, 64'h0);
    tick();
    chk("post_rst_waddr", rf_waddr, 64'd12);
    drive_rand(1'b0);
    tick();
    chk("post_rst_cnt", retire_cnt, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
